uc_seq: RTL and testbench
=========================

# uc_seq

Sequencing control unit for the single-cycle microcontroller datapath. It decodes the 6-bit `opcode` and the `z` flag into the datapath's mux selects, ALU operation and write enables. A run/halt/single-step state machine gates execution, and a retired-instruction counter is maintained. It sits beside the datapath: `dp_en` drives the datapath PC register load enable, and `we3`/`wez` are forced low whenever no instruction executes.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `opcode`  in  6  current instruction's opcode field (instruction bits 15:10).
- `z`  in  1  registered zero flag from the datapath.
- `run`  in  1  level; requests free-running execution.
- `stop`  in  1  level; requests return to IDLE.
- `step`  in  1  single-step request; rising-edge sensitive.
- `s_abs`, `s_inc`, `s_inm`  out  1  datapath mux selects.
- `we3`  out  1  register file write enable.
- `wez`  out  1  Z flag write enable.
- `op`  out  3  ALU operation.
- `dp_en`  out  1  PC load enable; high exactly on executing cycles.
- `halted`  out  1  state is IDLE or HALT.
- `err`  out  1  state is ERR.
- `icount`  out  CNT_W  retired-instruction count.

## Operation
- Encoding (bits `opcode[5:0]`):
  - `1ooo xx`: ALU. `op=opcode[4:2]`, `we3=1`, `wez=1`, `s_inc=1`.
  - `0100 xx`: LI. `s_inm=1`, `we3=1`, `s_inc=1`.
  - `000000`: NOP. `s_inc=1`.
  - `000001`: J. `s_abs=1`.
  - `000010`: JZ. If `z`, `s_inc=0`/`s_abs=0` (PC + offset, 10-bit wrap); otherwise `s_inc=1`.
  - `000011`: JNZ. Same as JZ with the condition inverted.
  - `001111`: HALT.
  - All other codes are illegal.
- `exec` is the internal execute qualifier.
  - When `exec=1`: decoded values drive the outputs, `dp_en=1`, and `icount` increments (wrapping).
  - When `exec=0`: `dp_en=0`, `we3=0`, `wez=0`, `s_abs=0`, `s_inc=1`, `s_inm=0`, `op=0`.
  - Any unlisted select is 0.
- States: IDLE (reset), RUN, HALT, ERR.
- `step_edge = step & ~step_q`. `step_q` is registered every cycle in every state.
- IDLE, evaluated in priority order:
  - `run`, or `step_edge` with no `run`, while `opcode` is illegal: `exec=0`, go to ERR.
  - `run`: `exec=1`, go to RUN.
  - `step_edge`: `exec=1`, stay in IDLE. A HALT opcode here executes as a HALT, so it moves to HALT with `exec=0`.
  - Otherwise: `exec=0`.
- RUN, evaluated in priority order:
  - Illegal opcode: `exec=0`, go to ERR.
  - `stop`: `exec=0`, go to IDLE.
  - HALT opcode: `exec=0`, go to HALT. The PC stays on the HALT word.
  - Otherwise: `exec=1`.
  - `step` is ignored.
- HALT:
  - `run`: the HALT word is executed as a NOP (`exec=1`, `s_inc=1`), go to RUN.
  - `step_edge` (no `run`): the HALT word is executed as a NOP, stay in HALT.
  - Otherwise: `exec=0`.
  - `stop` is ignored.
- ERR: `exec=0` permanently. Only `reset` exits.

## Timing
- Decode outputs are combinational from state, `opcode`, `z`, `run`, `stop` and `step_edge`. They are valid in the same cycle the instruction is presented, as the single-cycle datapath requires.
- The state, `step_q` and `icount` registers update on the rising edge after the qualifying cycle. `halted` and `err` are registered.
- Latency:
  - `run` asserted in IDLE: the first instruction executes in that same cycle.
  - `stop` in RUN: takes effect in the same cycle; no instruction retires.
- Reset values: IDLE, `halted=1`, `err=0`, `icount=0`, `step_q=0`, `dp_en=0`, `we3=0`, `wez=0`.
- Reset asserted mid-run clears all state immediately. The next cycle after reset deassertion is IDLE even if `run` is still high; with `run` still high, execution resumes in that cycle.
- A `step` held high produces exactly one executed instruction.
- `run` and `step_edge` together: `run` wins, and no extra instruction is counted.

## Test plan
- Reset, then hold `run=0`, `step=0` for 5 cycles -> `dp_en=0`, `we3=0`, `halted=1`, `icount=0`.
- IDLE, opcode `110100` (ALU, op 5), `run=1` -> same cycle: `op=5`, `we3=1`, `wez=1`, `s_inc=1`, `dp_en=1`; next cycle: state RUN, `icount=1`.
- RUN, opcode `000010`, first with `z=1` then with `z=0` -> `s_inc=0`, `s_abs=0`; then `s_inc=1`.
- RUN, opcode `001111` -> `dp_en=0`, next state HALT, `halted=1`. Then `step` low->high held 4 cycles -> exactly one `dp_en` pulse with `s_inc=1`, `icount` +1, state stays HALT.
- RUN, opcode `011000` (illegal) with `stop=1` -> `dp_en=0`, next state ERR, `err=1`. `run` and `step` for 10 cycles -> no `dp_en`. Reset -> IDLE, `err=0`.
- Preload `icount` near wrap with `CNT_W=4`: run 17 NOPs -> `icount` = 1. Assert `reset` mid-run -> outputs immediately at reset values.

Source files
------------

// File: rtl/uc_seq.sv
// Sequencing control for the single-cycle microcontroller datapath: opcode decode,
// run/halt/single-step execution gating and a retired-instruction counter.
module uc_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             z,
    input  logic             run,
    input  logic             stop,
    input  logic             step,
    output logic             s_abs,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       op,
    output logic             dp_en,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] icount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             step_q;
    logic             step_edge;
    logic             exec;
    logic             nop_force;
    logic             legal;
    logic             is_halt;
    logic             d_abs;
    logic             d_inc;
    logic             d_inm;
    logic             d_we3;
    logic             d_wez;
    logic [2:0]       d_op;
    logic             halted_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt;

    assign step_edge = step & ~step_q;

    always_comb begin
        legal   = 1'b1;
        is_halt = 1'b0;
        d_abs   = 1'b0;
        d_inc   = 1'b0;
        d_inm   = 1'b0;
        d_we3   = 1'b0;
        d_wez   = 1'b0;
        d_op    = 3'd0;
        if (opcode[5]) begin
            d_op  = opcode[4:2];
            d_we3 = 1'b1;
            d_wez = 1'b1;
            d_inc = 1'b1;
        end else if (opcode[5:2] == 4'b0100) begin
            d_inm = 1'b1;
            d_we3 = 1'b1;
            d_inc = 1'b1;
        end else begin
            case (opcode)
                6'b000000: d_inc = 1'b1;
                6'b000001: d_abs = 1'b1;
                // Conditional branches fall through (PC+1) when not taken, else PC+offset
                6'b000010: d_inc = ~z;
                6'b000011: d_inc = z;
                6'b001111: is_halt = 1'b1;
                default:   legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        exec       = 1'b0;
        nop_force  = 1'b0;
        case (state)
            IDLE: begin
                if ((run | step_edge) & ~legal) begin
                    state_next = ERR;
                end else if (run | step_edge) begin
                    // A HALT word executes as a halt: no retire, park in HALT
                    if (is_halt) begin
                        state_next = HALT;
                    end else begin
                        exec = 1'b1;
                        if (run) state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (!legal) begin
                    state_next = ERR;
                end else if (stop) begin
                    state_next = IDLE;
                end else if (is_halt) begin
                    state_next = HALT;
                end else begin
                    exec = 1'b1;
                end
            end
            HALT: begin
                if (run) begin
                    exec       = 1'b1;
                    nop_force  = 1'b1;
                    state_next = RUN;
                end else if (step_edge) begin
                    exec      = 1'b1;
                    nop_force = 1'b1;
                end
            end
            default: begin
                state_next = ERR;
            end
        endcase
        // Asynchronous reset must silence the datapath enables immediately
        if (reset) exec = 1'b0;
    end

    always_comb begin
        s_abs = 1'b0;
        s_inc = 1'b1;
        s_inm = 1'b0;
        we3   = 1'b0;
        wez   = 1'b0;
        op    = 3'd0;
        dp_en = exec;
        if (exec && !nop_force) begin
            s_abs = d_abs;
            s_inc = d_inc;
            s_inm = d_inm;
            we3   = d_we3;
            wez   = d_wez;
            op    = d_op;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            step_q   <= 1'b0;
            halted_q <= 1'b1;
            err_q    <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_next;
            step_q   <= step;
            halted_q <= (state_next == IDLE) || (state_next == HALT);
            err_q    <= (state_next == ERR);
            if (exec) cnt <= cnt + 1'b1;
        end
    end

    assign halted = halted_q;
    assign err    = err_q;
    assign icount = cnt;

endmodule

// File: tb/tb_uc_seq.sv
// Scoreboard bench for uc_seq: the driver queues expected decode on each executing
// cycle, an independent monitor pops and compares whenever dp_en is seen high.
module tb_uc_seq;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       opcode;
    logic             z;
    logic             run;
    logic             stop;
    logic             step;
    logic             s_abs;
    logic             s_inc;
    logic             s_inm;
    logic             we3;
    logic             wez;
    logic [2:0]       op;
    logic             dp_en;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] icount;

    typedef struct packed {
        logic       s_abs;
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op;
    } dec_t;

    dec_t             expq[$];
    logic [CNT_W-1:0] exp_cnt;
    int               checks = 0;
    int               errors = 0;

    localparam dec_t D_NONE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    localparam dec_t D_NOP  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    localparam dec_t D_J    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    localparam dec_t D_LI   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
    localparam dec_t D_ALU5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5};
    localparam dec_t D_ALU2 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2};

    uc_seq #(.CNT_W(CNT_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .opcode (opcode),
        .z      (z),
        .run    (run),
        .stop   (stop),
        .step   (step),
        .s_abs  (s_abs),
        .s_inc  (s_inc),
        .s_inm  (s_inm),
        .we3    (we3),
        .wez    (wez),
        .op     (op),
        .dp_en  (dp_en),
        .halted (halted),
        .err    (err),
        .icount (icount)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        dec_t a;
        dec_t e;
        if (dp_en === 1'b1) begin
            checks++;
            a = '{s_abs, s_inc, s_inm, we3, wez, op};
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_exec: dp_en=1 decode=%b, required no execution", a);
            end else begin
                e = expq.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL exec_decode: got {abs,inc,inm,we3,wez,op}=%b required %b", a, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // One clock of stimulus; called just after a rising edge
    task automatic drive(input logic [5:0] o, input logic zz, input logic r, input logic sp,
                         input logic st, input logic ex, input dec_t e);
        opcode = o;
        z      = zz;
        run    = r;
        stop   = sp;
        step   = st;
        if (ex) expq.push_back(e);
        @(negedge clk);
        chk("dp_en", {31'd0, dp_en}, {31'd0, ex});
        if (!ex) begin
            chk("we3_gated", {31'd0, we3}, 32'd0);
            chk("wez_gated", {31'd0, wez}, 32'd0);
            chk("s_inc_gated", {31'd0, s_inc}, 32'd1);
        end
        @(posedge clk);
        #1;
        if (ex) exp_cnt = exp_cnt + 1'b1;
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 6'd0;
        z      = 1'b0;
        run    = 1'b0;
        stop   = 1'b0;
        step   = 1'b0;
        exp_cnt = '0;
        #2;
        chk("rst_halted", {31'd0, halted}, 32'd1);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_icount", {28'd0, icount}, 32'd0);
        chk("rst_dp_en", {31'd0, dp_en}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle with no requests
        for (int i = 0; i < 5; i++) drive(6'b000000, 0, 0, 0, 0, 0, D_NONE);
        chk("idle_halted", {31'd0, halted}, 32'd1);
        chk("idle_icount", {28'd0, icount}, 32'd0);

        // Single step of LI from IDLE stays in IDLE
        drive(6'b010010, 0, 0, 0, 1, 1, D_LI);
        drive(6'b010010, 0, 0, 0, 1, 0, D_NONE);
        chk("step_idle_halted", {31'd0, halted}, 32'd1);
        chk("step_idle_icount", {28'd0, icount}, {28'd0, exp_cnt});

        // run in IDLE: ALU op 5 executes in the same cycle
        step = 1'b0;
        drive(6'b110100, 0, 1, 0, 0, 1, D_ALU5);
        chk("run_halted", {31'd0, halted}, 32'd0);
        chk("run_icount", {28'd0, icount}, 32'd2);

        // Branch and misc decode while running
        drive(6'b000010, 1, 1, 0, 0, 1, D_NONE);
        drive(6'b000010, 0, 1, 0, 0, 1, D_NOP);
        drive(6'b000011, 0, 1, 0, 0, 1, D_NONE);
        drive(6'b000011, 1, 1, 0, 0, 1, D_NOP);
        drive(6'b000001, 0, 1, 0, 0, 1, D_J);
        drive(6'b101011, 0, 1, 0, 0, 1, D_ALU2);
        chk("branch_icount", {28'd0, icount}, 32'd8);

        // HALT from RUN, then a held step retires exactly one NOP
        drive(6'b001111, 0, 1, 0, 0, 0, D_NONE);
        chk("halt_halted", {31'd0, halted}, 32'd1);
        drive(6'b001111, 0, 0, 0, 1, 1, D_NOP);
        for (int i = 0; i < 3; i++) drive(6'b001111, 0, 0, 0, 1, 0, D_NONE);
        chk("halt_step_icount", {28'd0, icount}, 32'd9);
        chk("halt_step_halted", {31'd0, halted}, 32'd1);
        // run with a fresh step edge: single NOP, back to RUN
        drive(6'b001111, 0, 0, 0, 0, 0, D_NONE);
        drive(6'b001111, 0, 1, 0, 1, 1, D_NOP);
        chk("halt_run_halted", {31'd0, halted}, 32'd0);
        chk("halt_run_icount", {28'd0, icount}, 32'd10);

        // stop in RUN on a legal opcode returns to IDLE with no retire
        drive(6'b000000, 0, 1, 1, 0, 0, D_NONE);
        chk("stop_halted", {31'd0, halted}, 32'd1);
        drive(6'b000000, 0, 1, 0, 0, 1, D_NOP);

        // Illegal opcode wins over stop
        drive(6'b011000, 0, 1, 1, 0, 0, D_NONE);
        chk("err_set", {31'd0, err}, 32'd1);
        chk("err_halted", {31'd0, halted}, 32'd0);
        for (int i = 0; i < 10; i++) drive(6'b000000, 0, 1, 0, i[0], 0, D_NONE);
        chk("err_held", {31'd0, err}, 32'd1);
        chk("err_icount", {28'd0, icount}, 32'd11);
        reset = 1'b1;
        #1;
        chk("err_reset_err", {31'd0, err}, 32'd0);
        chk("err_reset_halted", {31'd0, halted}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_cnt = '0;

        // Counter wrap at CNT_W=4; run and step edge together count once
        drive(6'b000000, 0, 1, 0, 1, 1, D_NOP);
        step = 1'b0;
        for (int i = 0; i < 16; i++) drive(6'b000000, 0, 1, 0, 0, 1, D_NOP);
        chk("wrap_icount", {28'd0, icount}, 32'd1);
        chk("wrap_model", {28'd0, icount}, {28'd0, exp_cnt});

        // Asynchronous reset mid-run with run held high
        opcode = 6'b110100;
        reset  = 1'b1;
        #1;
        chk("midrst_dp_en", {31'd0, dp_en}, 32'd0);
        chk("midrst_we3", {31'd0, we3}, 32'd0);
        chk("midrst_wez", {31'd0, wez}, 32'd0);
        chk("midrst_halted", {31'd0, halted}, 32'd1);
        chk("midrst_icount", {28'd0, icount}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_cnt = '0;
        drive(6'b110100, 0, 1, 0, 0, 1, D_ALU5);
        chk("post_rst_icount", {28'd0, icount}, 32'd1);
        chk("post_rst_halted", {31'd0, halted}, 32'd0);

        drive(6'b000000, 0, 0, 1, 0, 0, D_NONE);
        chk("queue_drained", expq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
